// File: rtl/fifo_v4.sv
// fifo_v4: circular-buffer queue with valid/ready streams on both sides,
// full-range usage count, run-time almost-full/almost-empty thresholds,
// a clearable high-water mark, optional fall-through and any depth >= 1.

module fifo_v4 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             testmode_i,
    input  dtype             data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output dtype             data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usage_o,
    input  logic [CNT_W-1:0] alm_full_th_i,
    input  logic [CNT_W-1:0] alm_empty_th_i,
    output logic             alm_full_o,
    output logic             alm_empty_o,
    input  logic             hwm_clr_i,
    output logic [CNT_W-1:0] hwm_o
);

    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    // Explicit wrap so non-power-of-two depths stay inside the buffer.
    function automatic logic [ADDR_DEPTH-1:0] ptr_inc(input logic [ADDR_DEPTH-1:0] p);
        logic [ADDR_DEPTH-1:0] r;
        if (p == LAST_PTR) begin
            r = {ADDR_DEPTH{1'b0}};
        end else begin
            r = p + ADDR_DEPTH'(1);
        end
        return r;
    endfunction

    logic [ADDR_DEPTH-1:0] rptr_q, rptr_d;
    logic [ADDR_DEPTH-1:0] wptr_q, wptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CNT_W-1:0]      hwm_q, hwm_d;
    dtype                  mem_q [DEPTH];
    dtype                  mem_d [DEPTH];
    logic [DEPTH-1:0]      mem_en_s;

    logic full_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;
    logic we_s;
    logic deq_s;

    // Handshake and flag derivation; flags use only the registered count.
    assign full_s   = (count_q == DEPTH_C);
    assign bypass_s = (FALL_THROUGH == 1'b1) && (count_q == {CNT_W{1'b0}});
    assign ready_o  = ~full_s;
    assign valid_o  = bypass_s ? valid_i : (count_q != {CNT_W{1'b0}});
    assign data_o   = bypass_s ? data_i : mem_q[rptr_q];
    assign empty_o  = (count_q == {CNT_W{1'b0}}) & ~((FALL_THROUGH == 1'b1) & valid_i);
    assign push_s   = valid_i & ready_o;
    assign pop_s    = valid_o & ready_i;
    // A bypassed push that is consumed at once never touches storage.
    assign we_s     = push_s & ~(bypass_s & pop_s) & ~flush_i;
    assign deq_s    = pop_s & ~bypass_s;

    assign full_o      = full_s;
    assign usage_o     = count_q;
    assign hwm_o       = hwm_q;
    assign alm_full_o  = (count_q >= alm_full_th_i);
    assign alm_empty_o = (count_q <= alm_empty_th_i);

    // Next-state for pointers, count and high-water mark.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        hwm_d   = hwm_q;
        if (flush_i) begin
            rptr_d  = {ADDR_DEPTH{1'b0}};
            wptr_d  = {ADDR_DEPTH{1'b0}};
            count_d = {CNT_W{1'b0}};
            hwm_d   = {CNT_W{1'b0}};
        end else begin
            if (we_s) begin
                wptr_d = ptr_inc(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end
            if (deq_s) begin
                rptr_d = ptr_inc(rptr_q);
            end else begin
                rptr_d = rptr_q;
            end
            case ({we_s, deq_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (hwm_clr_i) begin
                hwm_d = count_d;
            end else if (count_d > hwm_q) begin
                hwm_d = count_d;
            end else begin
                hwm_d = hwm_q;
            end
        end
    end

    // Per-entry write enable; scan forces every enable on while holding contents.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we_s && (wptr_q == ADDR_DEPTH'(i))) begin
                mem_en_s[i] = 1'b1;
                mem_d[i]    = data_i;
            end else begin
                mem_en_s[i] = testmode_i;
                mem_d[i]    = mem_q[i];
            end
        end
    end

    // Queue control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= {ADDR_DEPTH{1'b0}};
            wptr_q  <= {ADDR_DEPTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            hwm_q   <= {CNT_W{1'b0}};
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            hwm_q   <= hwm_d;
        end
    end

    // Entry storage, cleared on reset and loaded only through its enable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_en_s[i]) begin
                    mem_q[i] <= mem_d[i];
                end
            end
        end
    end

    fifo_v4_chk #(
        .FALL_THROUGH (FALL_THROUGH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH),
        .dtype        (dtype)
    ) u_chk (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .data_o         (data_o),
        .count_i        (count_q),
        .alm_full_th_i  (alm_full_th_i),
        .alm_empty_th_i (alm_empty_th_i)
    );

endmodule

// fifo_v4_chk: property checks for fifo_v4 (ignored by synthesis).
module fifo_v4_chk #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input logic             clk_i,
    input logic             rst_ni,
    input logic             flush_i,
    input logic             ready_i,
    input logic             valid_o,
    input dtype             data_o,
    input logic [CNT_W-1:0] count_i,
    input logic [CNT_W-1:0] alm_full_th_i,
    input logic [CNT_W-1:0] alm_empty_th_i
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    a_depth: assert property (@(posedge clk_i) DEPTH >= 1);
    a_afth:  assert property (@(posedge clk_i) disable iff (!rst_ni) alm_full_th_i <= DEPTH_C);
    a_aeth:  assert property (@(posedge clk_i) disable iff (!rst_ni) alm_empty_th_i <= DEPTH_C);
    a_usage: assert property (@(posedge clk_i) disable iff (!rst_ni) count_i <= DEPTH_C);

    if (FALL_THROUGH == 1'b0) begin : g_stable
        a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
                    (valid_o && !ready_i && !flush_i) |=> $stable(data_o));
    end

endmodule

// File: tb/tb_fifo_v4.sv
// Directed bench for fifo_v4: a normal-mode DEPTH=5 instance checked against
// a queue scoreboard every cycle, plus a fall-through instance.
module tb_fifo_v4;

    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, testmode, vin, rdy_in, hclr;
    logic [7:0] din;
    logic [2:0] afth, aeth;
    logic       rdy_out, vout, full, empty, afull, aempty;
    logic [7:0] dout;
    logic [2:0] usage, hwm;

    logic       b_vin, b_rdy_in, b_zero;
    logic [7:0] b_din;
    logic [2:0] b_zero3;
    logic       b_rdy_out, b_vout, b_full, b_empty, b_afull, b_aempty;
    logic [7:0] b_dout;
    logic [2:0] b_usage, b_hwm;

    int         total = 0;
    int         bad   = 0;
    int         n_pop = 0;
    int         m_hwm = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    fifo_v4 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(DEPTH)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .testmode_i(testmode),
        .data_i(din), .valid_i(vin), .ready_o(rdy_out), .data_o(dout),
        .valid_o(vout), .ready_i(rdy_in), .full_o(full), .empty_o(empty),
        .usage_o(usage), .alm_full_th_i(afth), .alm_empty_th_i(aeth),
        .alm_full_o(afull), .alm_empty_o(aempty), .hwm_clr_i(hclr), .hwm_o(hwm)
    );

    fifo_v4 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(DEPTH)) u_dut_ft (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_zero), .testmode_i(b_zero),
        .data_i(b_din), .valid_i(b_vin), .ready_o(b_rdy_out), .data_o(b_dout),
        .valid_o(b_vout), .ready_i(b_rdy_in), .full_o(b_full), .empty_o(b_empty),
        .usage_o(b_usage), .alm_full_th_i(b_zero3), .alm_empty_th_i(b_zero3),
        .alm_full_o(b_afull), .alm_empty_o(b_aempty), .hwm_clr_i(b_zero), .hwm_o(b_hwm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock of the normal instance: check flags against the model,
    // score any pop, then update the model and advance past the edge.
    task automatic step();
        int cnt;
        bit pu, po;
        #1;
        cnt = sb.size();
        chk("usage_o",     32'(usage),   32'(cnt));
        chk("ready_o",     32'(rdy_out), 32'(cnt != DEPTH));
        chk("valid_o",     32'(vout),    32'(cnt != 0));
        chk("empty_o",     32'(empty),   32'(cnt == 0));
        chk("full_o",      32'(full),    32'(cnt == DEPTH));
        chk("alm_full_o",  32'(afull),   32'(cnt >= int'(afth)));
        chk("alm_empty_o", 32'(aempty),  32'(cnt <= int'(aeth)));
        chk("hwm_o",       32'(hwm),     32'(m_hwm));
        pu = vin && (cnt != DEPTH);
        po = (cnt != 0) && rdy_in;
        if (po) begin
            chk("data_o", 32'(dout), 32'(sb[0]));
            n_pop++;
        end
        if (flush) begin
            sb.delete();
            m_hwm = 0;
        end else begin
            if (po) void'(sb.pop_front());
            if (pu) sb.push_back(din);
            if (hclr) m_hwm = sb.size();
            else if (sb.size() > m_hwm) m_hwm = sb.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit r);
        vin    = v;
        din    = d;
        rdy_in = r;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int guard;
        rst_n = 1'b0; flush = 1'b0; testmode = 1'b0; vin = 1'b0; rdy_in = 1'b0;
        hclr = 1'b0; din = 8'h00; afth = 3'd0; aeth = 3'd0;
        b_vin = 1'b0; b_rdy_in = 1'b0; b_din = 8'h00; b_zero = 1'b0; b_zero3 = 3'd0;

        // Reset values
        #2;
        chk("rst_usage", 32'(usage), 32'd0);
        chk("rst_hwm", 32'(hwm), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(rdy_out), 32'd1);
        chk("rst_valid", 32'(vout), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_alm_empty", 32'(aempty), 32'd1);
        chk("rst_alm_full_th0", 32'(afull), 32'd1);
        b_vin = 1'b1; b_din = 8'h3C;
        #1;
        chk("rst_ft_valid", 32'(b_vout), 32'd1);
        chk("rst_ft_empty", 32'(b_empty), 32'd0);
        chk("rst_ft_data", 32'(b_dout), 32'h3C);
        b_vin = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1; afth = 3'd3; aeth = 3'd1;

        // Fill to full, then a refused sixth push
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_ready", 32'(rdy_out), 32'd0);
        chk("fill_usage", 32'(usage), 32'd5);
        chk("fill_hwm", 32'(hwm), 32'd5);
        drive(1'b1, 8'h15, 1'b0);
        chk("sixth_usage", 32'(usage), 32'd5);

        // Streaming from full with wrap-around
        p0 = n_pop;
        for (int i = 0; i < 12; i++) drive(1'b1, 8'(8'h15 + i), 1'b1);
        chk("stream_pops", 32'(n_pop - p0), 32'd12);
        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            drive(1'b0, 8'h00, 1'b1);
            guard++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Almost-full / almost-empty thresholds
        drive(1'b1, 8'h20, 1'b0);
        chk("ae_after1", 32'(aempty), 32'd1);
        drive(1'b1, 8'h21, 1'b0);
        chk("ae_after2", 32'(aempty), 32'd0);
        chk("af_after2", 32'(afull), 32'd0);
        drive(1'b1, 8'h22, 1'b0);
        chk("af_after3", 32'(afull), 32'd1);
        testmode = 1'b1;
        drive(1'b0, 8'h99, 1'b0);
        testmode = 1'b0;
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        chk("pop2_af", 32'(afull), 32'd0);
        chk("pop2_ae", 32'(aempty), 32'd1);
        drive(1'b0, 8'h00, 1'b1);

        // Flush with a simultaneous push
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h30 + i), 1'b0);
        flush = 1'b1;
        drive(1'b1, 8'h77, 1'b1);
        flush = 1'b0;
        chk("flush_usage", 32'(usage), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_hwm", 32'(hwm), 32'd0);
        drive(1'b1, 8'h01, 1'b0);
        drive(1'b0, 8'h00, 1'b1);

        // High-water mark clear
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        chk("hwm_fill3", 32'(hwm), 32'd3);
        hclr = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        hclr = 1'b0;
        chk("hwm_clr_hold", 32'(hwm), 32'd3);
        hclr = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        hclr = 1'b0;
        chk("hwm_clr_pop", 32'(hwm), 32'd2);

        // Asynchronous reset mid-stream
        vin = 1'b1; din = 8'h55; rdy_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_usage", 32'(usage), 32'd0);
        chk("arst_hwm", 32'(hwm), 32'd0);
        chk("arst_full", 32'(full), 32'd0);
        chk("arst_ready", 32'(rdy_out), 32'd1);
        chk("arst_valid", 32'(vout), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_alm_empty", 32'(aempty), 32'd1);
        chk("arst_alm_full", 32'(afull), 32'd0);
        sb.delete();
        m_hwm = 0;
        vin = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'h66, 1'b0);
        drive(1'b0, 8'h00, 1'b1);

        // Fall-through instance
        b_vin = 1'b1; b_din = 8'hA5; b_rdy_in = 1'b1;
        #1;
        chk("ft_valid", 32'(b_vout), 32'd1);
        chk("ft_data", 32'(b_dout), 32'hA5);
        chk("ft_empty", 32'(b_empty), 32'd0);
        @(posedge clk);
        #1;
        chk("ft_usage", 32'(b_usage), 32'd0);
        chk("ft_hwm", 32'(b_hwm), 32'd0);
        b_din = 8'h5A; b_rdy_in = 1'b0;
        @(posedge clk);
        #1;
        b_vin = 1'b0; b_din = 8'h00;
        #1;
        chk("ft_store_usage", 32'(b_usage), 32'd1);
        chk("ft_store_valid", 32'(b_vout), 32'd1);
        chk("ft_store_data", 32'(b_dout), 32'h5A);
        b_rdy_in = 1'b1;
        @(posedge clk);
        #1;
        b_rdy_in = 1'b0;
        #1;
        chk("ft_drain_usage", 32'(b_usage), 32'd0);
        chk("ft_drain_valid", 32'(b_vout), 32'd0);
        chk("ft_drain_empty", 32'(b_empty), 32'd1);
        chk("ft_drain_hwm", 32'(b_hwm), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_v4.md
Name: fifo_v4

Overview:
- Parametrised successor to the common-cells FIFO. It is a circular-buffer queue with a valid/ready stream interface on both sides.
- Adds a full-range usage count, run-time almost-full/almost-empty thresholds and a clearable high-water-mark register.
- Supports optional fall-through and arbitrary (non-power-of-two) depth.
- Used as the standard decoupling buffer between pipeline stages and for credit/back-pressure monitoring.

Parameters:
- FALL_THROUGH, 1'b0, head output combinationally bypasses storage when the queue is empty.
- DATA_WIDTH, 32, entry width when dtype is not overridden.
- DEPTH, 8, number of entries; must be >= 1; need not be a power of two.
- dtype, logic [DATA_WIDTH-1:0], entry type.
- ADDR_DEPTH, (DEPTH>1)?$clog2(DEPTH):1, pointer width; derived, not overridden.
- CNT_W, $clog2(DEPTH+1), count width so that the value DEPTH is representable; derived.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- flush_i  in  1  synchronous flush of queue state.
- testmode_i  in  1  forces storage clock-gate enable during scan.
- data_i  in  dtype  write data.
- valid_i  in  1  write request.
- ready_o  out  1  write accept; equals ~full_o.
- data_o  out  dtype  head-of-queue data.
- valid_o  out  1  head valid; equals ~empty_o.
- ready_i  in  1  consumer accepts head.
- full_o  out  1  usage == DEPTH.
- empty_o  out  1  no data available at the output.
- usage_o  out  CNT_W  current entry count, 0..DEPTH.
- alm_full_th_i  in  CNT_W  almost-full threshold.
- alm_empty_th_i  in  CNT_W  almost-empty threshold.
- alm_full_o  out  1  usage_o >= alm_full_th_i.
- alm_empty_o  out  1  usage_o <= alm_empty_th_i.
- hwm_clr_i  in  1  clear high-water mark.
- hwm_o  out  CNT_W  maximum usage since the last reset, flush or clear.

Behaviour:
- Reset: rst_ni is asynchronous, active-low; clock is clk_i.
  - Pointers, count and hwm reset to 0.
  - Outputs after reset: usage_o=0, hwm_o=0, full_o=0, ready_o=1, alm_empty_o=1 (for any threshold), alm_full_o=(alm_full_th_i==0).
  - empty_o=1 and valid_o=0, except when FALL_THROUGH=1 and valid_i=1.
  - Storage is reset to 0 and written only on an accepted push.
- Handshake:
  - push = valid_i & ready_o.
  - pop = valid_o & ready_i.
  - valid_o must not depend on ready_i. ready_o must not depend on valid_i.
- Full: ready_o=0 when full, even if a pop occurs in the same cycle. There is no full-cycle pass-through.
- Latency, normal mode: an entry pushed in cycle N is visible on data_o/valid_o in cycle N+1.
- Latency, FALL_THROUGH=1 with usage==0:
  - valid_o=valid_i and data_o=data_i combinationally.
  - Push and pop in the same cycle leave pointers and count unchanged.
- Simultaneous push and pop (not the fall-through case): both pointers advance and usage is unchanged.
- Pointers wrap from DEPTH-1 to 0 explicitly; this is correct for non-power-of-two depths.
- Flags:
  - full_o, alm_full_o and alm_empty_o derive from the registered count only; they update in the cycle after the handshake.
  - empty_o = (count==0) & ~(FALL_THROUGH & valid_i).
- High-water mark: hwm_q <= max(hwm_q, usage_n) every cycle.
  - hwm_clr_i loads usage_n instead of the max.
  - flush_i clears hwm to 0.
- Flush:
  - Pointers and count are 0 in the next cycle.
  - Any push or pop in the flush cycle is accepted by the handshake but discarded.
  - Storage is not cleared.
  - Flush has priority over hwm_clr_i.
- Reset mid-operation: all state is lost immediately. No pending transfers survive.
- Assertions (non-synthesis):
  - DEPTH >= 1.
  - alm_full_th_i <= DEPTH.
  - alm_empty_th_i <= DEPTH.
  - usage never exceeds DEPTH.
  - data_o is stable while valid_o & ~ready_i and no flush occurs (normal mode only).

Test Plan:
- DEPTH=5, DATA_WIDTH=8, FALL_THROUGH=0. Push 0x10..0x14 with ready_i=0 -> full_o=1, ready_o=0, usage_o=5, hwm_o=5. A sixth push with valid_i=1 is not accepted.
- From full, hold ready_i=1 and valid_i=1 for 12 cycles with incrementing data -> output order is 0x10,0x11,… with no loss or duplication, and pointers wrap past 4->0 at least twice.
- alm_full_th_i=3, alm_empty_th_i=1. Push 3 entries one per cycle -> alm_empty_o falls the cycle after the 2nd push and alm_full_o rises the cycle after the 3rd. Pop 2 -> alm_full_o=0 and alm_empty_o=1.
- FALL_THROUGH=1, empty, valid_i=1, data_i=0xA5, ready_i=1 -> data_o=0xA5 and valid_o=1 in the same cycle. usage_o stays 0 and hwm_o stays 0.
- Fill 4 entries, then assert flush_i together with a push of 0x77 -> the next cycle gives usage_o=0, empty_o=1, hwm_o=0, and 0x77 never appears at the output.
- Fill 3 entries, pulse hwm_clr_i, pop 1 -> hwm_o=3 then 2. Assert rst_ni low mid-stream -> all outputs take their reset values asynchronously.
